// File: rtl/alu_escalonador.sv
// Round-robin scheduler sharing one 4-bit ALU between two requesters; accept -> response 2 cycles later.
// One command in flight; requesters see ready=0 until the response handshake completes.
module alu_escalonador #(
   parameter int LARGURA   = 4,
   parameter int LARG_CONT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [2:0]           req0_op,
   input  logic [LARGURA-1:0]   req0_a,
   input  logic [LARGURA-1:0]   req0_b,
   input  logic                 req0_encadear,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [2:0]           req1_op,
   input  logic [LARGURA-1:0]   req1_a,
   input  logic [LARGURA-1:0]   req1_b,
   input  logic                 req1_encadear,
   output logic [LARGURA-1:0]   alu_a,
   output logic [LARGURA-1:0]   alu_b,
   output logic [2:0]           alu_selecao,
   input  logic [LARGURA-1:0]   alu_resultado,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [LARGURA-1:0]   resp_dado,
   output logic                 resp_id,
   output logic [LARGURA-1:0]   acumulador,
   output logic [LARG_CONT-1:0] contador_ops,
   output logic                 ocupado
);

   typedef struct packed {
      logic [2:0]         op;
      logic [LARGURA-1:0] a;
      logic [LARGURA-1:0] b;
      logic               encadear;
   } cmd_t;

   typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

   estado_t estado, prox_estado;
   logic    ptr;
   logic    sel;
   logic    concede;
   cmd_t    cmd0, cmd1, cmd;

   assign cmd0 = {req0_op, req0_a, req0_b, req0_encadear};
   assign cmd1 = {req1_op, req1_a, req1_b, req1_encadear};

   // With a single valid requester it wins outright; ptr only breaks ties.
   assign sel = (req0_valid && req1_valid) ? ptr : req1_valid;
   assign cmd = sel ? cmd1 : cmd0;

   assign ocupado = (estado != OCIOSO);

   always_comb begin
      prox_estado = estado;
      concede     = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp_valid  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (!rst && (req0_valid || req1_valid)) begin
               concede     = 1'b1;
               req0_ready  = ~sel;
               req1_ready  = sel;
               prox_estado = EXECUTA;
            end
         end
         EXECUTA: prox_estado = RESPONDE;
         RESPONDE: begin
            resp_valid = 1'b1;
            if (resp_ready) prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado       <= OCIOSO;
         ptr          <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_selecao  <= '0;
         resp_dado    <= '0;
         resp_id      <= 1'b0;
         acumulador   <= '0;
         contador_ops <= '0;
      end else begin
         estado <= prox_estado;
         if (concede) begin
            // Accumulator is sampled at grant time so back-to-back chains see the latest result.
            alu_a       <= cmd.encadear ? acumulador : cmd.a;
            alu_b       <= cmd.b;
            alu_selecao <= cmd.op;
            resp_id     <= sel;
         end
         if (estado == EXECUTA) begin
            resp_dado    <= alu_resultado;
            acumulador   <= alu_resultado;
            contador_ops <= contador_ops + LARG_CONT'(1);
         end
         if (estado == RESPONDE && resp_ready) ptr <= ~resp_id;
      end
   end

endmodule

// File: tb/tb_alu_escalonador.sv
// Directed bench for alu_escalonador with a behavioural 4-bit ALU attached.
module tb_alu_escalonador;

   localparam int LARGURA   = 4;
   localparam int LARG_CONT = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 req0_valid, req0_ready, req0_encadear;
   logic [2:0]           req0_op;
   logic [LARGURA-1:0]   req0_a, req0_b;
   logic                 req1_valid, req1_ready, req1_encadear;
   logic [2:0]           req1_op;
   logic [LARGURA-1:0]   req1_a, req1_b;
   logic [LARGURA-1:0]   alu_a, alu_b, alu_resultado;
   logic [2:0]           alu_selecao;
   logic                 resp_valid, resp_ready, resp_id, ocupado;
   logic [LARGURA-1:0]   resp_dado, acumulador;
   logic [LARG_CONT-1:0] contador_ops;

   int total     = 0;
   int aprovados = 0;

   alu_escalonador #(.LARGURA(LARGURA), .LARG_CONT(LARG_CONT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_encadear(req0_encadear),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_encadear(req1_encadear),
      .alu_a(alu_a), .alu_b(alu_b), .alu_selecao(alu_selecao), .alu_resultado(alu_resultado),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dado(resp_dado), .resp_id(resp_id),
      .acumulador(acumulador), .contador_ops(contador_ops), .ocupado(ocupado)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_resultado = '0;
      case (alu_selecao)
         3'd0: alu_resultado = alu_a + alu_b;
         3'd1: alu_resultado = alu_a - alu_b;
         3'd2: alu_resultado = alu_a << 1;
         3'd3: alu_resultado = alu_a >> 1;
         3'd4: alu_resultado = alu_a & alu_b;
         3'd5: alu_resultado = alu_a | alu_b;
         3'd6: alu_resultado = alu_a ^ alu_b;
         default: alu_resultado = ~alu_a;
      endcase
   end

   task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
      total++;
      if (obtido === esperado) aprovados++;
      else $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
   endtask

   task automatic dirige(input logic porta, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic enc);
      if (porta == 1'b0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_encadear = enc;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_encadear = enc;
      end
   endtask

   // Called on a falling edge; returns 1 ns later in the cycle whose ready is high.
   task automatic espera_ready(input logic porta);
      int n = 0;
      #1;
      while (((porta ? req1_ready : req0_ready) !== 1'b1) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      verifica("ready_concedido", porta ? req1_ready : req0_ready, 1);
   endtask

   task automatic espera_resp();
      int n = 0;
      #1;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      verifica("resp_valid_chega", resp_valid, 1);
   endtask

   // Full command with resp_ready high; starts and ends on a falling edge.
   task automatic transacao(input logic porta, input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic enc,
                            output logic [3:0] dado, output logic id, output logic [7:0] cnt);
      dirige(porta, 1'b1, op, a, b, enc);
      espera_ready(porta);
      @(negedge clk);
      dirige(porta, 1'b0, op, a, b, enc);
      espera_resp();
      dado = resp_dado; id = resp_id; cnt = contador_ops;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulacao nao terminou");
      $fatal(1);
   end

   initial begin
      logic [3:0] d;
      logic       id;
      logic [7:0] c;

      rst = 1'b1; resp_ready = 1'b0;
      dirige(0, 1'b1, 3'd0, 4'd0, 4'd0, 1'b0);
      dirige(1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      verifica("rst_req0_ready", req0_ready, 0);
      verifica("rst_alu_a", alu_a, 0);
      verifica("rst_alu_selecao", alu_selecao, 0);
      verifica("rst_resp_valid", resp_valid, 0);
      verifica("rst_acumulador", acumulador, 0);
      verifica("rst_contador", contador_ops, 0);
      verifica("rst_ocupado", ocupado, 0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single add, step by step.
      resp_ready = 1'b1;
      dirige(0, 1'b1, 3'd0, 4'd3, 4'd4, 1'b0);
      #1;
      verifica("t1_req0_ready", req0_ready, 1);
      verifica("t1_req1_ready", req1_ready, 0);
      @(negedge clk);
      dirige(0, 1'b0, 3'd0, 4'd3, 4'd4, 1'b0);
      #1;
      verifica("t1_alu_a", alu_a, 3);
      verifica("t1_alu_b", alu_b, 4);
      verifica("t1_ocupado", ocupado, 1);
      verifica("t1_resp_valid_cedo", resp_valid, 0);
      @(negedge clk);
      #1;
      verifica("t1_resp_valid", resp_valid, 1);
      verifica("t1_resp_dado", resp_dado, 7);
      verifica("t1_resp_id", resp_id, 0);
      verifica("t1_acumulador", acumulador, 7);
      verifica("t1_contador", contador_ops, 1);
      @(negedge clk);
      #1;
      verifica("t1_resp_valid_cai", resp_valid, 0);
      verifica("t1_ocioso", ocupado, 0);
      @(negedge clk);

      // Modular wrap through the ALU.
      transacao(1, 3'd0, 4'd9, 4'd9, 1'b0, d, id, c);
      verifica("wrap_add_dado", d, 4'h2);
      verifica("wrap_add_id", id, 1);
      transacao(1, 3'd1, 4'd1, 4'd2, 1'b0, d, id, c);
      verifica("wrap_sub_dado", d, 4'hF);
      verifica("wrap_sub_cont", c, 3);

      // Both requesters valid continuously: strict alternation from ptr=0.
      dirige(0, 1'b1, 3'd1, 4'd9, 4'd2, 1'b0);
      dirige(1, 1'b1, 3'd4, 4'hC, 4'hA, 1'b0);
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         #1;
         while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         verifica("alt_ready_exclusivo", req0_ready & req1_ready, 0);
         verifica("alt_ordem", req1_ready, k[0]);
         @(negedge clk);
         espera_resp();
         verifica("alt_dado", resp_dado, k[0] ? 4'h8 : 4'h7);
         verifica("alt_id", resp_id, k[0]);
         @(negedge clk);
      end
      dirige(0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      dirige(1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      #1;
      verifica("alt_sem_aceite", ocupado, 0);
      verifica("alt_contador", contador_ops, 7);
      @(negedge clk);

      // Chaining: 5+5, then acumulador ^ 0xF (a input ignored).
      transacao(0, 3'd0, 4'd5, 4'd5, 1'b0, d, id, c);
      verifica("enc_base", d, 4'hA);
      dirige(0, 1'b1, 3'd6, 4'd3, 4'hF, 1'b1);
      espera_ready(0);
      @(negedge clk);
      dirige(0, 1'b0, 3'd6, 4'd3, 4'hF, 1'b1);
      #1;
      verifica("enc_alu_a", alu_a, 4'hA);
      verifica("enc_alu_selecao", alu_selecao, 6);
      espera_resp();
      verifica("enc_dado", resp_dado, 4'h5);
      verifica("enc_cont", contador_ops, 9);
      @(negedge clk);

      // Backpressure: resp_ready low for 5 cycles while req1 keeps asking.
      resp_ready = 1'b0;
      dirige(1, 1'b1, 3'd5, 4'd1, 4'd2, 1'b0);
      espera_ready(1);
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         #1;
         verifica("bp_resp_valid", resp_valid, 1);
         verifica("bp_resp_dado", resp_dado, 4'h3);
         verifica("bp_req1_ready", req1_ready, 0);
         verifica("bp_ocupado", ocupado, 1);
         @(negedge clk);
      end
      verifica("bp_cont", contador_ops, 10);
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      verifica("bp_resp_valid_cai", resp_valid, 0);
      verifica("bp_req1_regrant", req1_ready, 1);
      @(negedge clk);
      dirige(1, 1'b0, 3'd5, 4'd1, 4'd2, 1'b0);
      espera_resp();
      verifica("bp_segundo_dado", resp_dado, 4'h3);
      verifica("bp_segundo_cont", contador_ops, 11);
      @(negedge clk);

      // Counter wrap 255 -> 0.
      for (int i = 0; i < 244; i++) transacao(0, 3'd7, 4'd5, 4'd0, 1'b0, d, id, c);
      verifica("cont_255", c, 255);
      verifica("not_dado", d, 4'hA);
      transacao(0, 3'd7, 4'd5, 4'd0, 1'b0, d, id, c);
      verifica("cont_wrap_0", c, 0);
      transacao(1, 3'd6, 4'd3, 4'd5, 1'b0, d, id, c);
      verifica("pre_rst_dado", d, 4'h6);
      verifica("pre_rst_cont", c, 1);

      // Async reset in the middle of EXECUTA.
      dirige(0, 1'b1, 3'd0, 4'd3, 4'd4, 1'b0);
      espera_ready(0);
      @(negedge clk);
      dirige(0, 1'b0, 3'd0, 4'd3, 4'd4, 1'b0);
      #1;
      verifica("mid_ocupado", ocupado, 1);
      rst = 1'b1;
      #1;
      verifica("arst_alu_a", alu_a, 0);
      verifica("arst_alu_b", alu_b, 0);
      verifica("arst_acumulador", acumulador, 0);
      verifica("arst_contador", contador_ops, 0);
      verifica("arst_ocupado", ocupado, 0);
      verifica("arst_resp_id", resp_id, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         #1;
         verifica("arst_sem_resp", resp_valid, 0);
      end
      verifica("arst_cont_final", contador_ops, 0);

      $display("%0d/%0d checks passed", aprovados, total);
      $finish;
   end

endmodule
